// File: rtl/fpnew_pkg.sv
// Shared FPU types and helpers used by the opgroup blocks and the result arbiter.
package fpnew_pkg;

    localparam int unsigned NUM_OPGROUPS = 4;

    typedef enum logic [1:0] {
        ADDMUL  = 2'd0,
        DIVSQRT = 2'd1,
        NONCOMP = 2'd2,
        CONV    = 2'd3
    } opgroup_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    // Round-robin pointer advance; ptr is always below n, so no divider is needed.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fpnew_rr_select.sv
// Combinational round-robin selector: first set request at or above ptr, else wrap to the lowest.
module fpnew_rr_select #(
    parameter int unsigned NumIn = 4,
    parameter int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic [NumIn-1:0] req,
    input  logic [IdxW-1:0]  ptr,
    output logic [NumIn-1:0] gnt,
    output logic [IdxW-1:0]  idx,
    output logic             any_valid
);

    logic            found_hi;
    logic            found_lo;
    logic [IdxW-1:0] idx_hi;
    logic [IdxW-1:0] idx_lo;

    // Two scans instead of a rotate: one over the indices at/above ptr, one over all.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            if (!found_hi && req[i] && (i >= int'(ptr))) begin
                found_hi = 1'b1;
                idx_hi   = IdxW'(i);
            end
            if (!found_lo && req[i]) begin
                found_lo = 1'b1;
                idx_lo   = IdxW'(i);
            end
        end
        idx       = found_hi ? idx_hi : idx_lo;
        any_valid = found_lo;
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            gnt[i] = any_valid && (idx == IdxW'(i));
        end
    end

endmodule

// File: rtl/fpnew_result_arbiter.sv
// Merges the opgroup result streams onto the FPU result port through one output register.
module fpnew_result_arbiter
    import fpnew_pkg::*;
#(
    parameter int unsigned NumIn    = NUM_OPGROUPS,
    parameter int unsigned Width    = 64,
    parameter int unsigned TagWidth = 1,
    localparam int unsigned IdxW    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic [NumIn-1:0]                   in_valid_i,
    output logic [NumIn-1:0]                   in_ready_o,
    input  logic [NumIn-1:0][Width-1:0]        in_result_i,
    input  status_t [NumIn-1:0]                in_status_i,
    input  logic [NumIn-1:0][TagWidth-1:0]     in_tag_i,
    input  logic [NumIn-1:0]                   in_ext_bit_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [Width-1:0]                   out_result_o,
    output status_t                            out_status_o,
    output logic [TagWidth-1:0]                out_tag_o,
    output logic                               out_ext_bit_o,
    output logic [IdxW-1:0]                    out_src_o,
    output logic                               busy_o
);

    // Handshake: a transfer happens on a port in any cycle where valid and ready are both high;
    // upstream holds valid and payload stable until then, ready here never depends on being accepted elsewhere.
    logic [IdxW-1:0]     rr_q;
    logic [NumIn-1:0]    gnt;
    logic [IdxW-1:0]     gnt_idx;
    logic                any_valid;
    logic                ld;
    logic                accept;

    logic                out_valid_q;
    logic [Width-1:0]    result_q;
    status_t             status_q;
    logic [TagWidth-1:0] tag_q;
    logic                ext_bit_q;
    logic [IdxW-1:0]     src_q;

    fpnew_rr_select #(
        .NumIn (NumIn),
        .IdxW  (IdxW)
    ) u_rr_select (
        .req       (in_valid_i),
        .ptr       (rr_q),
        .gnt       (gnt),
        .idx       (gnt_idx),
        .any_valid (any_valid)
    );

    assign ld         = ~flush_i & (~out_valid_q | out_ready_i);
    assign accept     = ld & any_valid;
    assign in_ready_o = gnt & {NumIn{accept}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            tag_q       <= '0;
            ext_bit_q   <= 1'b0;
            src_q       <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= in_result_i[gnt_idx];
            status_q    <= in_status_i[gnt_idx];
            tag_q       <= in_tag_i[gnt_idx];
            ext_bit_q   <= in_ext_bit_i[gnt_idx];
            src_q       <= gnt_idx;
            rr_q        <= IdxW'(rr_next(32'(gnt_idx), NumIn));
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_result_o  = result_q;
    assign out_status_o  = status_q;
    assign out_tag_o     = tag_q;
    assign out_ext_bit_o = ext_bit_q;
    assign out_src_o     = src_q;
    assign busy_o        = out_valid_q;

endmodule
